// File: rtl/vgachargen_ctrl_pkg.sv
// Shared types and constants for the vgachargen APB controller.
package vgachargen_ctrl_pkg;

    typedef enum logic [1:0] {
        REG_CH_MAP  = 2'd0,
        REG_COL_MAP = 2'd1,
        REG_CH_TIFF = 2'd2,
        REG_RSVD    = 2'd3
    } region_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_CAPT,
        RD_RESP,
        ERR
    } state_e;

    localparam int DEF_CH_MAP_WORDS  = 600;
    localparam int DEF_COL_MAP_WORDS = 600;
    localparam int DEF_CH_TIFF_WORDS = 1024;
    localparam int DEF_MEM_ADDR_W    = 10;

    localparam logic [15:0] STATUS_ID = 16'h56C6;

    // One-hot write-enable pattern {char_tiff, col_map, char_map} for a region.
    function automatic logic [2:0] region_we(input region_e r);
        case (r)
            REG_CH_MAP:  return 3'b001;
            REG_COL_MAP: return 3'b010;
            REG_CH_TIFF: return 3'b100;
            default:     return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/apb_vgachargen_ctrl_if.sv
// APB3 slave-side bus bundle for the vgachargen controller.
interface apb_vgachargen_ctrl_if;

    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [13:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [3:0]  pstrb_i;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        output pready_o, prdata_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        input  pready_o, prdata_o, pslverr_o
    );

endinterface

// File: rtl/apb_vgachargen_addr_dec.sv
// Combinational region/index decode with range and alignment checking.
// Region 3 index 0 becomes a readable status word when VGACHARGEN_CTRL_STATUS_EN is defined.
module apb_vgachargen_addr_dec
    import vgachargen_ctrl_pkg::*;
#(
    parameter int CH_MAP_WORDS  = DEF_CH_MAP_WORDS,
    parameter int COL_MAP_WORDS = DEF_COL_MAP_WORDS,
    parameter int CH_TIFF_WORDS = DEF_CH_TIFF_WORDS
) (
    input  logic [13:0] paddr,
    output region_e     region,
    output logic [9:0]  index,
    output logic        err,
    output logic        status_sel
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        region     = region_e'(paddr[13:12]);
        index      = paddr[11:2];
        err        = (paddr[1:0] != 2'b00);
        status_sel = 1'b0;
        case (region)
            REG_CH_MAP:  err = err | (32'(index) >= CH_MAP_WORDS);
            REG_COL_MAP: err = err | (32'(index) >= COL_MAP_WORDS);
            REG_CH_TIFF: err = err | (32'(index) >= CH_TIFF_WORDS);
            default: begin
`ifdef VGACHARGEN_CTRL_STATUS_EN
                err        = err | (index != 10'd0);
                status_sel = 1'b1;
`else
                err        = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/apb_vgachargen_ctrl.sv
// APB3 slave sequencing CPU accesses into the vgachargen char/colour/font memories.
// Optional write-count status word under VGACHARGEN_CTRL_STATUS_EN.
module apb_vgachargen_ctrl
    import vgachargen_ctrl_pkg::*;
#(
    parameter int CH_MAP_WORDS  = DEF_CH_MAP_WORDS,
    parameter int COL_MAP_WORDS = DEF_COL_MAP_WORDS,
    parameter int CH_TIFF_WORDS = DEF_CH_TIFF_WORDS,
    parameter int MEM_ADDR_W    = DEF_MEM_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    apb_vgachargen_ctrl_if.slave  apb,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  char_map_we_o,
    output logic                  col_map_we_o,
    output logic                  char_tiff_we_o,
    input  logic [31:0]           char_map_rdata_i,
    input  logic [31:0]           col_map_rdata_i,
    input  logic [31:0]           char_tiff_rdata_i
);

    state_e      state, state_nxt;
    region_e     dec_region, region_q;
    logic [9:0]  dec_index;
    logic        dec_err, dec_status, req_err;
    logic [2:0]  we_q;
    logic [31:0] rd_sel, prdata_q;
    logic        setup;

    apb_vgachargen_addr_dec #(
        .CH_MAP_WORDS (CH_MAP_WORDS),
        .COL_MAP_WORDS(COL_MAP_WORDS),
        .CH_TIFF_WORDS(CH_TIFF_WORDS)
    ) u_dec (
        .paddr     (apb.paddr_i),
        .region    (dec_region),
        .index     (dec_index),
        .err       (dec_err),
        .status_sel(dec_status)
    );

    assign setup   = (state == IDLE) && apb.psel_i && !apb.penable_i;
    assign req_err = dec_err || (dec_status && apb.pwrite_i);

    always_comb begin
        state_nxt     = state;
        apb.pready_o  = 1'b0;
        apb.pslverr_o = 1'b0;
        case (state)
            IDLE:    if (setup) state_nxt = req_err ? ERR : (apb.pwrite_i ? WR : RD_ADDR);
            WR:      begin state_nxt = IDLE; apb.pready_o = apb.psel_i; end
            RD_ADDR: state_nxt = RD_CAPT;
            RD_CAPT: state_nxt = RD_RESP;
            RD_RESP: begin state_nxt = IDLE; apb.pready_o = apb.psel_i; end
            ERR: begin
                state_nxt     = IDLE;
                apb.pready_o  = apb.psel_i;
                apb.pslverr_o = apb.psel_i;
            end
            default: state_nxt = IDLE;
        endcase
        // A master dropping psel mid-transfer abandons it without a response.
        if (state != IDLE && !apb.psel_i) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

`ifdef VGACHARGEN_CTRL_STATUS_EN
    logic [15:0] wr_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          wr_count <= 16'd0;
        else if (state == WR && apb.psel_i) wr_count <= wr_count + 16'd1;
    end
`endif

    always_comb begin
        rd_sel = 32'd0;
        case (region_q)
            REG_CH_MAP:  rd_sel = char_map_rdata_i;
            REG_COL_MAP: rd_sel = col_map_rdata_i;
            REG_CH_TIFF: rd_sel = char_tiff_rdata_i;
            default: begin
`ifdef VGACHARGEN_CTRL_STATUS_EN
                rd_sel = {STATUS_ID, wr_count};
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_addr_o  <= '0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
            region_q    <= REG_CH_MAP;
            we_q        <= 3'b000;
            prdata_q    <= 32'd0;
        end else begin
            we_q <= 3'b000;
            if (setup) begin
                mem_addr_o  <= MEM_ADDR_W'(dec_index);
                mem_be_o    <= apb.pstrb_i;
                mem_wdata_o <= apb.pwdata_i;
                region_q    <= dec_region;
                if (req_err)            prdata_q <= 32'd0;
                else if (apb.pwrite_i)  we_q     <= region_we(dec_region);
            end
            if (state == RD_CAPT && apb.psel_i) prdata_q <= rd_sel;
        end
    end

    assign apb.prdata_o = prdata_q;

    // Strobes are qualified by psel so a transfer aborted right after setup never writes.
    assign char_map_we_o  = we_q[0] && apb.psel_i;
    assign col_map_we_o   = we_q[1] && apb.psel_i;
    assign char_tiff_we_o = we_q[2] && apb.psel_i;

endmodule

// File: tb/tb_apb_vgachargen_ctrl.sv
// Directed bench for apb_vgachargen_ctrl with behavioural 1-cycle sync-read memories.
// Status-word expectations follow VGACHARGEN_CTRL_STATUS_EN.
module tb_apb_vgachargen_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        char_map_we, col_map_we, char_tiff_we;
    logic [31:0] char_map_rdata, col_map_rdata, char_tiff_rdata;

    logic [31:0] cm_mem   [1024];
    logic [31:0] col_mem  [1024];
    logic [31:0] tiff_mem [1024];

    int vectors     = 0;
    int miscompares = 0;

    apb_vgachargen_ctrl_if bus ();

    apb_vgachargen_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .apb              (bus),
        .mem_addr_o       (mem_addr),
        .mem_be_o         (mem_be),
        .mem_wdata_o      (mem_wdata),
        .char_map_we_o    (char_map_we),
        .col_map_we_o     (col_map_we),
        .char_tiff_we_o   (char_tiff_we),
        .char_map_rdata_i (char_map_rdata),
        .col_map_rdata_i  (col_map_rdata),
        .char_tiff_rdata_i(char_tiff_rdata)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (char_map_we  && mem_be[b]) cm_mem[mem_addr][8*b +: 8]   <= mem_wdata[8*b +: 8];
            if (col_map_we   && mem_be[b]) col_mem[mem_addr][8*b +: 8]  <= mem_wdata[8*b +: 8];
            if (char_tiff_we && mem_be[b]) tiff_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        char_map_rdata  <= cm_mem[mem_addr];
        col_map_rdata   <= col_mem[mem_addr];
        char_tiff_rdata <= tiff_mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer starting from an idle bus at posedge+1; reports what the bench saw.
    task automatic xfer(input logic [13:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, output int waits, output logic [31:0] rd,
                        output logic err, output logic [2:0] we_seen, output int we_cyc,
                        output logic [9:0] w_addr, output logic [3:0] w_be);
        logic [2:0] we_now;
        waits = 0; rd = '0; err = 1'b0; we_seen = '0; we_cyc = 0; w_addr = '0; w_be = '0;
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
        bus.paddr_i = a;   bus.pwdata_i = wd;    bus.pstrb_i = st;
        @(posedge clk_i); #1 bus.penable_i = 1'b1;
        forever begin
            @(negedge clk_i);
            we_now = {char_tiff_we, col_map_we, char_map_we};
            if (|we_now) begin
                we_seen |= we_now; we_cyc++; w_addr = mem_addr; w_be = mem_be;
            end
            if (bus.pready_o) begin
                rd = bus.prdata_o; err = bus.pslverr_o;
                break;
            end
            waits++;
            if (waits > 8) begin
                vectors++; miscompares++;
                $display("FAIL pready_timeout: no pready after %0d wait states for addr 0x%04h", waits, a);
                break;
            end
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1 bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, wc;
        logic [31:0] rd;
        logic        e;
        logic [2:0]  ws;
        logic [9:0]  wa;
        logic [3:0]  wb;

        rst_i = 1'b1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0;  bus.pwdata_i = '0;    bus.pstrb_i = '0;
        #1;
        check("rst_outputs", {bus.pready_o, bus.pslverr_o, char_map_we, col_map_we, char_tiff_we}, 32'd0);
        check("rst_prdata", bus.prdata_o, 32'd0);
        check("rst_mem_bus", {mem_addr, mem_be} | mem_wdata, 32'd0);
        @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Full-word write to colour map index 2, then read back.
        xfer(14'h1008, 1'b1, 32'hDEADBEEF, 4'b1111, w, rd, e, ws, wc, wa, wb);
        check("wr1008_waits", w, 0);
        check("wr1008_err", e, 0);
        check("wr1008_we", ws, 3'b010);
        check("wr1008_we_cycles", wc, 1);
        check("wr1008_addr", wa, 10'd2);
        xfer(14'h1008, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
        check("rd1008_waits", w, 2);
        check("rd1008_data", rd, 32'hDEADBEEF);
        check("rd1008_no_we", ws, 3'b000);

        // Partial-strobe write to char map index 0 over a known background.
        xfer(14'h0000, 1'b1, 32'hFFFFFFFF, 4'b1111, w, rd, e, ws, wc, wa, wb);
        xfer(14'h0000, 1'b1, 32'h11223344, 4'b0101, w, rd, e, ws, wc, wa, wb);
        check("wr0000_we", ws, 3'b001);
        check("wr0000_be", wb, 4'b0101);
        check("wr0000_we_cycles", wc, 1);
        xfer(14'h0000, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
        check("rd0000_data", rd, 32'hFF22FF44);

        // Error responses: out-of-range, misaligned, reserved.
        xfer(14'h0960, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
        check("err0960", {w[7:0], 7'd0, e, 13'd0, ws}, {8'd0, 7'd0, 1'b1, 13'd0, 3'b000});
        check("err0960_prdata", rd, 32'd0);
        xfer(14'h2FFE, 1'b1, 32'h12345678, 4'b1111, w, rd, e, ws, wc, wa, wb);
        check("err2FFE", {w[7:0], 7'd0, e, 13'd0, ws}, {8'd0, 7'd0, 1'b1, 13'd0, 3'b000});
        check("err2FFE_prdata", rd, 32'd0);
        xfer(14'h3004, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
        check("err3004", {w[7:0], 7'd0, e, 13'd0, ws}, {8'd0, 7'd0, 1'b1, 13'd0, 3'b000});

        // Abort: psel drops right after the setup of a char tiff write.
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
        bus.paddr_i = 14'h2010; bus.pwdata_i = 32'hCAFEF00D; bus.pstrb_i = 4'b1111;
        @(posedge clk_i); #1 bus.psel_i = 1'b0;
        @(negedge clk_i);
        check("abort_cyc1", {bus.pready_o, char_map_we, col_map_we, char_tiff_we}, 32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("abort_cyc2", {bus.pready_o, char_map_we, col_map_we, char_tiff_we}, 32'd0);
        @(posedge clk_i); #1;
        xfer(14'h1008, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
        check("post_abort_waits", w, 2);
        check("post_abort_data", rd, 32'hDEADBEEF);

        // Reset pulse while a read sits in RD_CAPT.
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = 14'h1008;
        @(posedge clk_i); #1 bus.penable_i = 1'b1;
        @(posedge clk_i); #3 rst_i = 1'b1;
        #1;
        check("midrd_rst_ctl", {bus.pready_o, bus.pslverr_o, char_map_we, col_map_we, char_tiff_we}, 32'd0);
        check("midrd_rst_prdata", bus.prdata_o, 32'd0);
        check("midrd_rst_mem", {18'd0, mem_addr, mem_be} | mem_wdata, 32'd0);
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        xfer(14'h1008, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
        check("post_rst_waits", w, 2);
        check("post_rst_data", rd, 32'hDEADBEEF);

        // Three successful writes since reset, including the last valid index of two regions.
        xfer(14'h2010, 1'b1, 32'hA5A5A5A5, 4'b1111, w, rd, e, ws, wc, wa, wb);
        check("wr2010_we", ws, 3'b100);
        xfer(14'h2FFC, 1'b1, 32'h0BADF00D, 4'b1111, w, rd, e, ws, wc, wa, wb);
        check("wr2FFC_ok", {e, ws, wa}, {1'b0, 3'b100, 10'd1023});
        xfer(14'h095C, 1'b1, 32'h600DCAFE, 4'b1111, w, rd, e, ws, wc, wa, wb);
        check("wr095C_ok", {e, ws, wa}, {1'b0, 3'b001, 10'd599});

        xfer(14'h3000, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
`ifdef VGACHARGEN_CTRL_STATUS_EN
        check("status_waits", w, 2);
        check("status_err", e, 0);
        check("status_data", rd, 32'h56C60003);
`else
        check("rsvd_waits", w, 0);
        check("rsvd_err", e, 1);
        check("rsvd_data", rd, 32'd0);
`endif
        xfer(14'h3000, 1'b1, 32'hFFFFFFFF, 4'b1111, w, rd, e, ws, wc, wa, wb);
        check("wr3000_err", {e, ws}, {1'b1, 3'b000});

        xfer(14'h2FFC, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
        check("rd2FFC_data", rd, 32'h0BADF00D);
        xfer(14'h095C, 1'b0, 32'h0, 4'b0000, w, rd, e, ws, wc, wa, wb);
        check("rd095C_data", rd, 32'h600DCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_vgachargen_ctrl.md
Name: apb_vgachargen_ctrl

Overview:
APB3 slave controller that sequences CPU accesses into the three vgachargen memories: char map, colour map and char tiff (font).
- Decodes the address region.
- Range-checks the word index.
- Issues a single-cycle write strobe, or runs the sync-read latency of the target memory and returns the read data.
- Sits between the system APB interconnect and vgachargen, in the clk_i domain.

Parameters:
CH_MAP_WORDS, 600, valid word count of char map
COL_MAP_WORDS, 600, valid word count of colour map
CH_TIFF_WORDS, 1024, valid word count of char tiff
MEM_ADDR_W, 10, memory word-address width

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
paddr_i  in  14  APB byte address
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
pready_o  out  1  APB ready
prdata_o  out  32  APB read data
pslverr_o  out  1  APB error
mem_addr_o  out  MEM_ADDR_W  shared word address to all three memories
mem_be_o  out  4  shared byte enables
mem_wdata_o  out  32  shared write data
char_map_we_o / col_map_we_o / char_tiff_we_o  out  1 each  per-memory write enable
char_map_rdata_i / col_map_rdata_i / char_tiff_rdata_i  in  32 each  per-memory read data (1-cycle sync read)

Behaviour:
- Address map (paddr_i[13:12]):
  - 0: char map
  - 1: colour map
  - 2: char tiff
  - 3: reserved
- Word index = paddr_i[11:2].
- Error conditions:
  - paddr_i[1:0]!=0
  - reserved region
  - index >= region's *_WORDS
- Reset (async, any state): state=IDLE. All outputs 0: pready_o, pslverr_o, prdata_o, mem_*, all we.
- Registered outputs: mem_addr_o, mem_be_o and mem_wdata_o are registered, loaded at the end of the setup cycle (IDLE & psel_i & !penable_i).
- FSM states: IDLE, WR, RD_ADDR, RD_CAPT, RD_RESP, ERR.
  - IDLE: on setup, decode and go to ERR, WR or RD_ADDR.
  - IDLE with psel_i&penable_i (protocol violation): ignored, stay IDLE.
  - WR (1st access cycle): the selected *_we_o=1 (registered), mem_be_o=pstrb_i captured, pready_o=1, pslverr_o=0 → IDLE. Zero wait states; the memory writes at the end of WR.
  - pstrb_i=0 on write: we still asserts with be=0; no byte changes.
  - RD_ADDR: memory samples mem_addr_o at end of cycle, pready_o=0 → RD_CAPT.
  - RD_CAPT: selected rdata_i captured into prdata_o register → RD_RESP.
  - RD_RESP: pready_o=1, prdata_o valid → IDLE. A read therefore shows 2 wait states: pready high in the 3rd access cycle.
  - ERR: pready_o=1, pslverr_o=1, prdata_o=0, no we → IDLE.
- pready_o/pslverr_o are high only in WR, RD_RESP and ERR.
- prdata_o:
  - Holds its value after RD_RESP until the next read capture or error.
  - Cleared in ERR.
- psel_i deasserted in any non-IDLE state: abort → IDLE. No we issued if abort precedes WR; no response.
- Only one we is ever high, and for exactly one cycle per write transfer.

Optional Feature:
VGACHARGEN_CTRL_STATUS_EN
- Defined:
  - Region 3 index 0 reads {16'h56C6, 16-bit wrapping count of completed successful writes} via the RD path timing (2 wait states).
  - Writes to region 3 → ERR; other region-3 indices → ERR.
  - Counter resets to 0 and wraps 0xFFFF→0.
- Undefined: region 3 is fully reserved (ERR); no counter logic.

Decomposition:
- Package vgachargen_ctrl_pkg:
  - region enum (REG_CH_MAP, REG_COL_MAP, REG_CH_TIFF, REG_RSVD)
  - FSM state enum
  - default word-count constants
  - STATUS_ID constant 16'h56C6
- Natural sub-module: apb_vgachargen_addr_dec. Combinational region/index decode plus error flag, reused by verification for reference modelling.

Test Plan:
- Reset mid-read (rst_i pulse during RD_CAPT) → all outputs 0 immediately, state IDLE; next transfer completes normally.
- Write 0xDEADBEEF, strb 4'b1111, to paddr 0x1008 → col_map_we_o=1 for one cycle with mem_addr_o=2, pready_o in 1st access cycle. Then read 0x1008 → pready_o in 3rd access cycle, prdata_o=0xDEADBEEF.
- Write strb 4'b0101 to 0x0000 → char_map_we_o=1, mem_be_o=4'b0101, other we low.
- Error cases, each → pready_o=1 and pslverr_o=1 in 1st access cycle, no we, prdata_o=0:
  - read 0x0960 (index 600 ≥ CH_MAP_WORDS)
  - write 0x2FFE (misaligned)
  - read 0x3004
- Abort: psel_i drops after setup of write to 0x2010 → no char_tiff_we_o; FSM in IDLE.
- With VGACHARGEN_CTRL_STATUS_EN: 3 successful writes then read 0x3000 → prdata_o=0x56C60003. Without the macro: the same read → pslverr_o=1.
